// File: rtl/ld_st_exec_unit.sv
// Load/store execute: pops the LSQ head, forms the address, issues one dmem access, returns the result on the CDB.
// Latency 5 cycles with a 1-cycle memory; holds the CDB request until granted and never pops while busy.
package ld_st_pkg;
  localparam int BMASK_W  = 4;
  localparam int BR_BIT_W = $clog2(BMASK_W);

  typedef struct packed {
    logic                valid;
    logic                ready;
    logic                is_store;
    logic [2:0]          funct3;
    logic [11:0]         imm;
    logic [5:0]          rd_paddr;
    logic [4:0]          rob_idx;
    logic [BMASK_W-1:0]  bmask;
  } ld_st_data_pkt_t;

  typedef struct packed {
    logic                cdb_broadcast;
    logic [5:0]          cdb_p_addr;
    logic [4:0]          rob_idx;
    logic [31:0]         data;
    logic                br_mispred;
    logic [BR_BIT_W-1:0] br_bit;
  } cdb_pkt_t;
endpackage

module ld_st_exec_unit #(
  parameter int BMASK_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  ld_st_pkg::ld_st_data_pkt_t q_head,
  input  logic                       q_empty,
  output logic                       q_ren,
  input  logic [31:0]                prf_rs1_v,
  input  logic [31:0]                prf_rs2_v,
  input  ld_st_pkg::cdb_pkt_t        br_pkt,
  output logic [31:0]                dmem_addr,
  output logic [3:0]                 dmem_rmask,
  output logic [3:0]                 dmem_wmask,
  output logic [31:0]                dmem_wdata,
  input  logic [31:0]                dmem_rdata,
  input  logic                       dmem_resp,
  output logic                       cdb_req,
  input  logic                       cdb_gnt,
  output ld_st_pkg::cdb_pkt_t        cdb_out
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    OPRD  = 3'd1,
    REQ   = 3'd2,
    WAIT  = 3'd3,
    BCAST = 3'd4,
    DRAIN = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic               is_store_q;
  logic [2:0]         funct3_q;
  logic [11:0]        imm_q;
  logic [5:0]         rd_paddr_q;
  logic [4:0]         rob_idx_q;
  logic [BMASK_W-1:0] bmask_q;
  logic [31:0]        addr_q;
  logic [31:0]        rs2_q;
  logic [31:0]        ld_data_q;

  logic               mispred;
  logic               resolve;
  logic               squash;
  logic [BMASK_W-1:0] clr_vec;
  logic               head_pop;
  logic               head_take;
  logic [1:0]         offset;
  logic [3:0]         acc_mask;
  logic [31:0]        ld_shift;
  logic [31:0]        ld_ext;

  logic unused_br;
  assign unused_br = ^{br_pkt.cdb_p_addr, br_pkt.rob_idx, br_pkt.data};

  assign mispred = br_pkt.cdb_broadcast & br_pkt.br_mispred;
  assign resolve = br_pkt.cdb_broadcast & ~br_pkt.br_mispred;
  assign squash  = mispred & bmask_q[br_pkt.br_bit] & (state_q != IDLE);
  assign clr_vec = resolve ? (BMASK_W'(1) << br_pkt.br_bit) : '0;

  // A mispredict rewinds the queue pointers, so the head must not be popped that cycle.
  assign head_pop  = rst_n & (state_q == IDLE) & ~q_empty & ~mispred &
                     (~q_head.valid | q_head.ready);
  assign head_take = head_pop & q_head.valid;

  assign offset   = addr_q[1:0];
  assign ld_shift = dmem_rdata >> {offset, 3'b000};

  always_comb begin
    acc_mask = 4'b1111;
    case (funct3_q[1:0])
      2'b00:   acc_mask = 4'b0001 << offset;
      2'b01:   acc_mask = 4'b0011 << offset;
      default: acc_mask = 4'b1111;
    endcase
  end

  always_comb begin
    ld_ext = ld_shift;
    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_ext = {24'd0, ld_shift[7:0]};
      3'b101:  ld_ext = {16'd0, ld_shift[15:0]};
      default: ld_ext = ld_shift;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_store_q <= 1'b0;
      funct3_q   <= '0;
      imm_q      <= '0;
      rd_paddr_q <= '0;
      rob_idx_q  <= '0;
      bmask_q    <= '0;
      addr_q     <= '0;
      rs2_q      <= '0;
      ld_data_q  <= '0;
    end else begin
      if (head_take) begin
        is_store_q <= q_head.is_store;
        funct3_q   <= q_head.funct3;
        imm_q      <= q_head.imm;
        rd_paddr_q <= q_head.rd_paddr;
        rob_idx_q  <= q_head.rob_idx;
        bmask_q    <= q_head.bmask & ~clr_vec;
      end else if (state_q != IDLE) begin
        bmask_q <= bmask_q & ~clr_vec;
      end
      if (state_q == OPRD) begin
        addr_q <= prf_rs1_v + {{20{imm_q[11]}}, imm_q};
        rs2_q  <= prf_rs2_v;
      end
      if ((state_q == REQ || state_q == WAIT) && dmem_resp && !squash) begin
        ld_data_q <= ld_ext;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    q_ren      = head_pop;
    dmem_addr  = '0;
    dmem_rmask = '0;
    dmem_wmask = '0;
    dmem_wdata = '0;
    cdb_req    = 1'b0;
    cdb_out    = '0;

    case (state_q)
      IDLE: begin
        if (head_take) state_d = OPRD;
      end
      OPRD: begin
        state_d = squash ? IDLE : REQ;
      end
      REQ: begin
        if (squash) begin
          state_d = IDLE;
        end else begin
          dmem_addr = {addr_q[31:2], 2'b00};
          if (is_store_q) begin
            dmem_wmask = acc_mask;
            dmem_wdata = rs2_q << {offset, 3'b000};
          end else begin
            dmem_rmask = acc_mask;
          end
          state_d = dmem_resp ? BCAST : WAIT;
        end
      end
      WAIT: begin
        // A response arriving alongside the squash closes the access; otherwise drain it later.
        if (squash) begin
          state_d = dmem_resp ? IDLE : DRAIN;
        end else if (dmem_resp) begin
          state_d = BCAST;
        end
      end
      BCAST: begin
        if (squash) begin
          state_d = IDLE;
        end else begin
          cdb_req               = 1'b1;
          cdb_out.cdb_broadcast = cdb_gnt;
          cdb_out.rob_idx       = rob_idx_q;
          if (!is_store_q) begin
            cdb_out.cdb_p_addr = rd_paddr_q;
            cdb_out.data       = ld_data_q;
          end
          if (cdb_gnt) state_d = IDLE;
        end
      end
      DRAIN: begin
        if (dmem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ld_st_exec_unit.sv
// Directed bench for ld_st_exec_unit: hand-computed vectors checked with immediate assertions.
module tb_ld_st_exec_unit;
  logic                       clk;
  logic                       rst_n;
  ld_st_pkg::ld_st_data_pkt_t q_head;
  logic                       q_empty;
  logic                       q_ren;
  logic [31:0]                prf_rs1_v;
  logic [31:0]                prf_rs2_v;
  ld_st_pkg::cdb_pkt_t        br_pkt;
  logic [31:0]                dmem_addr;
  logic [3:0]                 dmem_rmask;
  logic [3:0]                 dmem_wmask;
  logic [31:0]                dmem_wdata;
  logic [31:0]                dmem_rdata;
  logic                       dmem_resp;
  logic                       cdb_req;
  logic                       cdb_gnt;
  ld_st_pkg::cdb_pkt_t        cdb_out;

  int n_cmp = 0;
  int n_err = 0;

  ld_st_exec_unit #(.BMASK_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .q_head     (q_head),
    .q_empty    (q_empty),
    .q_ren      (q_ren),
    .prf_rs1_v  (prf_rs1_v),
    .prf_rs2_v  (prf_rs2_v),
    .br_pkt     (br_pkt),
    .dmem_addr  (dmem_addr),
    .dmem_rmask (dmem_rmask),
    .dmem_wmask (dmem_wmask),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_resp  (dmem_resp),
    .cdb_req    (cdb_req),
    .cdb_gnt    (cdb_gnt),
    .cdb_out    (cdb_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_head(input logic v, input logic r, input logic st, input logic [2:0] f3,
                          input logic [11:0] imm, input logic [5:0] rd, input logic [4:0] rob,
                          input logic [3:0] bm);
    q_head.valid    = v;
    q_head.ready    = r;
    q_head.is_store = st;
    q_head.funct3   = f3;
    q_head.imm      = imm;
    q_head.rd_paddr = rd;
    q_head.rob_idx  = rob;
    q_head.bmask    = bm;
    q_empty         = 1'b0;
  endtask

  task automatic set_br(input logic bc, input logic mp, input logic [1:0] bit_idx);
    br_pkt               = '0;
    br_pkt.cdb_broadcast = bc;
    br_pkt.br_mispred    = mp;
    br_pkt.br_bit        = bit_idx;
  endtask

  ld_st_pkg::cdb_pkt_t exp_pkt;

  initial begin
    rst_n      = 1'b0;
    q_head     = '0;
    q_empty    = 1'b1;
    prf_rs1_v  = '0;
    prf_rs2_v  = '0;
    br_pkt     = '0;
    dmem_rdata = '0;
    dmem_resp  = 1'b0;
    cdb_gnt    = 1'b0;

    // Reset: outputs idle even with a poppable head present
    set_head(1'b1, 1'b1, 1'b0, 3'b010, 12'd0, 6'd1, 5'd1, 4'd0);
    #3;
    chk("rst_q_ren", 64'(q_ren), 64'd0);
    chk("rst_addr", 64'(dmem_addr), 64'd0);
    chk("rst_masks", 64'({dmem_rmask, dmem_wmask}), 64'd0);
    chk("rst_cdb_req", 64'(cdb_req), 64'd0);
    chk("rst_cdb_out", 64'(cdb_out), 64'd0);
    q_empty = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;

    // LB sign extension: 0x1000+3, word 0x80FFFF12 -> 0xFFFFFF80
    tick();
    set_head(1'b1, 1'b1, 1'b0, 3'b000, 12'd3, 6'd7, 5'd3, 4'd0);
    #1 chk("lb_q_ren", 64'(q_ren), 64'd1);
    tick();
    q_empty = 1'b1; prf_rs1_v = 32'h1000; prf_rs2_v = 32'h0;
    #1 chk("lb_oprd_rmask", 64'(dmem_rmask), 64'd0);
    tick();
    prf_rs1_v = 32'h0;
    #1 chk("lb_addr", 64'(dmem_addr), 64'h1000);
    chk("lb_rmask", 64'(dmem_rmask), 64'h8);
    chk("lb_wmask", 64'(dmem_wmask), 64'h0);
    tick();
    dmem_resp = 1'b1; dmem_rdata = 32'h80FF_FF12;
    #1 chk("lb_wait_rmask", 64'(dmem_rmask), 64'd0);
    chk("lb_wait_addr", 64'(dmem_addr), 64'd0);
    tick();
    dmem_resp = 1'b0; cdb_gnt = 1'b1;
    #1 chk("lb_cdb_req", 64'(cdb_req), 64'd1);
    chk("lb_data", 64'(cdb_out.data), 64'hFFFF_FF80);
    chk("lb_paddr", 64'(cdb_out.cdb_p_addr), 64'd7);
    chk("lb_rob", 64'(cdb_out.rob_idx), 64'd3);
    chk("lb_bcast", 64'(cdb_out.cdb_broadcast), 64'd1);
    tick();
    cdb_gnt = 1'b0;
    #1 chk("lb_done_req", 64'(cdb_req), 64'd0);

    // SH: 0x2002, rs2 0xABCD -> wmask 0xC, wdata 0xABCD0000
    set_head(1'b1, 1'b1, 1'b1, 3'b001, 12'd0, 6'd9, 5'd4, 4'd0);
    #1 chk("sh_q_ren", 64'(q_ren), 64'd1);
    tick();
    q_empty = 1'b1; prf_rs1_v = 32'h2002; prf_rs2_v = 32'h0000_ABCD;
    tick();
    #1 chk("sh_addr", 64'(dmem_addr), 64'h2000);
    chk("sh_wmask", 64'(dmem_wmask), 64'hC);
    chk("sh_wdata", 64'(dmem_wdata), 64'hABCD_0000);
    chk("sh_rmask", 64'(dmem_rmask), 64'h0);
    tick();
    dmem_resp = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    #1 chk("sh_wait_wmask", 64'(dmem_wmask), 64'd0);
    tick();
    dmem_resp = 1'b0; cdb_gnt = 1'b1;
    #1 chk("sh_cdb_req", 64'(cdb_req), 64'd1);
    chk("sh_paddr", 64'(cdb_out.cdb_p_addr), 64'd0);
    chk("sh_data", 64'(cdb_out.data), 64'd0);
    chk("sh_rob", 64'(cdb_out.rob_idx), 64'd4);
    tick();
    cdb_gnt = 1'b0;

    // LHU with grant withheld 4 cycles: 0x3000-2 -> 0x2FFE, word 0xBEEF1234 -> 0xBEEF
    set_head(1'b1, 1'b1, 1'b0, 3'b101, 12'hFFE, 6'd12, 5'd5, 4'd0);
    #1;
    tick();
    q_empty = 1'b1; prf_rs1_v = 32'h3000;
    tick();
    #1 chk("lhu_addr", 64'(dmem_addr), 64'h2FFC);
    chk("lhu_rmask", 64'(dmem_rmask), 64'hC);
    tick();
    dmem_resp = 1'b1; dmem_rdata = 32'hBEEF_1234;
    tick();
    dmem_resp = 1'b0;
    set_head(1'b1, 1'b1, 1'b0, 3'b010, 12'd0, 6'd2, 5'd2, 4'd0);
    exp_pkt = '0;
    exp_pkt.cdb_p_addr = 6'd12;
    exp_pkt.rob_idx    = 5'd5;
    exp_pkt.data       = 32'h0000_BEEF;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      #1 chk("gd_req", 64'(cdb_req), 64'd1);
      chk("gd_pkt", 64'(cdb_out), 64'(exp_pkt));
      chk("gd_q_ren", 64'(q_ren), 64'd0);
    end
    tick();
    q_empty = 1'b1; cdb_gnt = 1'b1;
    exp_pkt.cdb_broadcast = 1'b1;
    #1 chk("gd_gnt_pkt", 64'(cdb_out), 64'(exp_pkt));
    tick();
    cdb_gnt = 1'b0;
    #1 chk("gd_done_req", 64'(cdb_req), 64'd0);

    // Squash in WAIT on bmask bit 1, memory answers 3 cycles later
    set_head(1'b1, 1'b1, 1'b0, 3'b010, 12'd0, 6'd20, 5'd6, 4'b0010);
    #1 chk("sq_q_ren", 64'(q_ren), 64'd1);
    tick();
    q_empty = 1'b1; prf_rs1_v = 32'h4000;
    tick();
    #1 chk("sq_rmask", 64'(dmem_rmask), 64'hF);
    tick();
    set_br(1'b1, 1'b1, 2'd1);
    #1;
    tick();
    set_br(1'b0, 1'b0, 2'd0);
    #1 chk("sq_drain_req1", 64'(cdb_req), 64'd0);
    chk("sq_drain_rmask", 64'(dmem_rmask), 64'd0);
    tick();
    #1 chk("sq_drain_req2", 64'(cdb_req), 64'd0);
    tick();
    dmem_resp = 1'b1; dmem_rdata = 32'h1111_1111;
    set_head(1'b1, 1'b1, 1'b0, 3'b000, 12'd0, 6'd21, 5'd7, 4'b0100);
    #1 chk("sq_resp_q_ren", 64'(q_ren), 64'd0);
    chk("sq_resp_req", 64'(cdb_req), 64'd0);
    tick();
    dmem_resp = 1'b0;
    #1 chk("sq_next_pop", 64'(q_ren), 64'd1);
    chk("sq_next_req", 64'(cdb_req), 64'd0);

    // bmask bit 2 resolved correctly, later mispredict on bit 2 must not squash
    tick();
    q_empty = 1'b1; prf_rs1_v = 32'h5001;
    tick();
    #1 chk("bm_addr", 64'(dmem_addr), 64'h5000);
    chk("bm_rmask", 64'(dmem_rmask), 64'h2);
    tick();
    set_br(1'b1, 1'b0, 2'd2);
    tick();
    set_br(1'b1, 1'b1, 2'd2);
    tick();
    set_br(1'b0, 1'b0, 2'd0);
    dmem_resp = 1'b1; dmem_rdata = 32'h0000_7F00;
    tick();
    dmem_resp = 1'b0; cdb_gnt = 1'b1;
    #1 chk("bm_cdb_req", 64'(cdb_req), 64'd1);
    chk("bm_data", 64'(cdb_out.data), 64'h7F);
    chk("bm_paddr", 64'(cdb_out.cdb_p_addr), 64'd21);
    tick();
    cdb_gnt = 1'b0;

    // Mispredict in IDLE suppresses the pop; invalid head is discarded
    set_head(1'b1, 1'b1, 1'b0, 3'b010, 12'd0, 6'd3, 5'd1, 4'd0);
    set_br(1'b1, 1'b1, 2'd0);
    #1 chk("mp_idle_q_ren", 64'(q_ren), 64'd0);
    tick();
    set_br(1'b0, 1'b0, 2'd0);
    set_head(1'b0, 1'b0, 1'b0, 3'b010, 12'd0, 6'd3, 5'd1, 4'd0);
    #1 chk("inv_q_ren", 64'(q_ren), 64'd1);
    tick();
    q_empty = 1'b1;
    #1 chk("inv_rmask", 64'(dmem_rmask), 64'd0);
    chk("inv_addr", 64'(dmem_addr), 64'd0);
    chk("inv_req", 64'(cdb_req), 64'd0);

    // Reset in REQ: outputs drop at once, stray response afterwards is ignored
    set_head(1'b1, 1'b1, 1'b0, 3'b010, 12'd0, 6'd3, 5'd1, 4'd0);
    #1 chk("inv_stay_idle", 64'(q_ren), 64'd1);
    tick();
    prf_rs1_v = 32'h6000;
    #1 chk("rm_oprd_q_ren", 64'(q_ren), 64'd0);
    tick();
    #1 chk("rm_rmask", 64'(dmem_rmask), 64'hF);
    rst_n = 1'b0;
    #1 chk("rm_rst_rmask", 64'(dmem_rmask), 64'd0);
    chk("rm_rst_addr", 64'(dmem_addr), 64'd0);
    chk("rm_rst_q_ren", 64'(q_ren), 64'd0);
    chk("rm_rst_req", 64'(cdb_req), 64'd0);
    tick();
    q_empty = 1'b1;
    rst_n = 1'b1;
    dmem_resp = 1'b1; dmem_rdata = 32'h2222_2222;
    tick();
    dmem_resp = 1'b0;
    #1 chk("rm_stray_req1", 64'(cdb_req), 64'd0);
    tick();
    #1 chk("rm_stray_req2", 64'(cdb_req), 64'd0);
    chk("rm_stray_pkt", 64'(cdb_out), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
